// File: rtl/pid_pkg.sv
// pid_pkg: shared widths, FSM state type and MAC slot helpers for pid_calc
package pid_pkg;
    localparam int ERR_W  = 24;
    localparam int GAIN_W = 16;
    localparam int ACC_W  = 42;
    localparam logic [1:0] PITCH = 2'd0;
    localparam logic [1:0] ROLL  = 2'd1;
    localparam logic [1:0] YAW   = 2'd2;
    localparam logic [1:0] P = 2'd0;
    localparam logic [1:0] I = 2'd1;
    localparam logic [1:0] D = 2'd2;
    typedef enum logic [1:0] {IDLE, MAC, OUT} pid_state_t;
    function automatic logic [3:0] slot(logic [1:0] axis, logic [1:0] term);
        return 4'({2'b00, axis} * 4'd3 + {2'b00, term});
    endfunction
    function automatic logic [1:0] axis_of(logic [3:0] idx);
        return 2'(idx / 4'd3);
    endfunction
    function automatic logic [1:0] term_of(logic [3:0] idx);
        return 2'(idx % 4'd3);
    endfunction
endpackage

// File: rtl/pid_sat.sv
// pid_sat: floor-shift the accumulator by FRAC_BITS, saturate to 24 bits, and
// clamp to +/-OUT_LIMIT when PID_OUT_CLAMP_EN is defined
module pid_sat
    import pid_pkg::*;
#(
    parameter int               FRAC_BITS = 8,
    parameter logic [ERR_W-1:0] OUT_LIMIT = 24'd500000
) (
    input  logic [ACC_W-1:0] acc,
    output logic [ERR_W-1:0] res
);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(8388607);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-8388608);
    logic signed [ACC_W-1:0] shifted;
    logic signed [ERR_W-1:0] sat;
    assign shifted = $signed(acc) >>> FRAC_BITS;
    assign sat = shifted > SAT_MAX ? {1'b0, {(ERR_W-1){1'b1}}} :
                 shifted < SAT_MIN ? {1'b1, {(ERR_W-1){1'b0}}} : shifted[ERR_W-1:0];
`ifdef PID_OUT_CLAMP_EN
    localparam logic signed [ERR_W-1:0] LIM = OUT_LIMIT;
    assign res = sat > LIM ? LIM : sat < -LIM ? -LIM : sat;
`else
    logic unused_limit;
    assign unused_limit = ^OUT_LIMIT;
    assign res = sat;
`endif
endmodule

// File: rtl/pid_calc.sv
// pid_calc: three-axis PID with one shared multiplier over nine MAC cycles;
// optional +/-OUT_LIMIT output clamp via PID_OUT_CLAMP_EN
module pid_calc
    import pid_pkg::*;
#(
    parameter int               FRAC_BITS = 8,
    parameter logic [ERR_W-1:0] OUT_LIMIT = 24'd500000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pid_en,
    input  logic [ERR_W-1:0]    pitch_error,
    input  logic [ERR_W-1:0]    roll_error,
    input  logic [ERR_W-1:0]    yaw_error,
    input  logic [ERR_W-1:0]    i_pitch_error,
    input  logic [ERR_W-1:0]    i_roll_error,
    input  logic [ERR_W-1:0]    i_yaw_error,
    input  logic [ERR_W-1:0]    d_pitch_error,
    input  logic [ERR_W-1:0]    d_roll_error,
    input  logic [ERR_W-1:0]    d_yaw_error,
    input  logic [3*GAIN_W-1:0] kp,
    input  logic [3*GAIN_W-1:0] ki,
    input  logic [3*GAIN_W-1:0] kd,
    output logic [ERR_W-1:0]    pitch_out,
    output logic [ERR_W-1:0]    roll_out,
    output logic [ERR_W-1:0]    yaw_out,
    output logic                busy,
    output logic                pid_done
);
    pid_state_t state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d, sum;
    logic signed [ERR_W+GAIN_W-1:0] prod;
    logic [8:0][ERR_W-1:0] err_q, err_d;
    logic [8:0][GAIN_W-1:0] gain_q, gain_d;
    logic [2:0][ERR_W-1:0] res_q, res_d, out_q, out_d;
    logic [ERR_W-1:0] wb;
    logic done_q, done_d;
    assign prod = $signed(err_q[idx_q]) * $signed(gain_q[idx_q]);
    assign sum  = acc_q + {{(ACC_W-ERR_W-GAIN_W){prod[ERR_W+GAIN_W-1]}}, prod};
    pid_sat #(.FRAC_BITS(FRAC_BITS), .OUT_LIMIT(OUT_LIMIT)) u_sat (.acc(sum), .res(wb));
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        err_d   = err_q;
        gain_d  = gain_q;
        res_d   = res_q;
        out_d   = out_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (pid_en) begin
                err_d[slot(PITCH, P)]  = pitch_error;
                err_d[slot(PITCH, I)]  = i_pitch_error;
                err_d[slot(PITCH, D)]  = d_pitch_error;
                err_d[slot(ROLL, P)]   = roll_error;
                err_d[slot(ROLL, I)]   = i_roll_error;
                err_d[slot(ROLL, D)]   = d_roll_error;
                err_d[slot(YAW, P)]    = yaw_error;
                err_d[slot(YAW, I)]    = i_yaw_error;
                err_d[slot(YAW, D)]    = d_yaw_error;
                gain_d[slot(PITCH, P)] = kp[15:0];
                gain_d[slot(PITCH, I)] = ki[15:0];
                gain_d[slot(PITCH, D)] = kd[15:0];
                gain_d[slot(ROLL, P)]  = kp[31:16];
                gain_d[slot(ROLL, I)]  = ki[31:16];
                gain_d[slot(ROLL, D)]  = kd[31:16];
                gain_d[slot(YAW, P)]   = kp[47:32];
                gain_d[slot(YAW, I)]   = ki[47:32];
                gain_d[slot(YAW, D)]   = kd[47:32];
                acc_d   = '0;
                idx_d   = '0;
                state_d = MAC;
            end
            MAC: begin
                // the D term closes an axis: write back and restart the sum
                acc_d   = term_of(idx_q) == D ? '0 : sum;
                if (term_of(idx_q) == D) res_d[axis_of(idx_q)] = wb;
                idx_d   = idx_q == 4'd8 ? 4'd0 : idx_q + 4'd1;
                state_d = idx_q == 4'd8 ? OUT : MAC;
            end
            OUT: begin
                out_d   = res_q;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            err_q   <= '0;
            gain_q  <= '0;
            res_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            err_q   <= err_d;
            gain_q  <= gain_d;
            res_q   <= res_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end
    assign pitch_out = out_q[PITCH];
    assign roll_out  = out_q[ROLL];
    assign yaw_out   = out_q[YAW];
    assign busy      = state_q != IDLE;
    assign pid_done  = done_q;
endmodule
